// File: rtl/capture_sequencer_pkg.sv
// Shared types and defaults for the histogram capture sequencer.
package capture_sequencer_pkg;

  // Sequencer states
  typedef enum logic [2:0] {
    StIdle,
    StArm,
    StCapture,
    StDrain,
    StGap
  } cs_state_e;

  // Run ownership encoding
  typedef enum logic {
    OwnA = 1'b0,
    OwnB = 1'b1
  } owner_e;

  localparam int unsigned DefLength    = 64;
  localparam int unsigned DefGapCycles = 32;
  localparam int unsigned DefTimeout   = 4000;

  // Round-robin pick: on a tie the requester that did not own the last run wins;
  // before any run has been granted, A wins the tie.
  function automatic owner_e rr_pick(logic req_a, logic req_b, logic ran, owner_e last);
    if (req_a && req_b) begin
      if (!ran) return OwnA;
      return (last == OwnA) ? OwnB : OwnA;
    end else if (req_b) begin
      return OwnB;
    end
    return OwnA;
  endfunction

endpackage

// File: rtl/capture_sequencer_tgl_sync.sv
// Two-flop synchronizer and edge detector for the clk-domain result toggle.
module capture_sequencer_tgl_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic tgl_i,
  output logic edge_o
);

  logic sync1_q, sync2_q, ref_q;

  // Synchronize the toggle and keep a reference copy; the reference always tracks,
  // so an edge nobody consumed cannot resurface later.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      ref_q   <= 1'b0;
    end else begin
      sync1_q <= tgl_i;
      sync2_q <= sync1_q;
      ref_q   <= sync2_q;
    end
  end

  assign edge_o = sync2_q ^ ref_q;

endmodule

// File: rtl/capture_sequencer.sv
// Capture run sequencer: arbitrates host/trigger requests, gates LENGTH samples
// into the datapath, waits for the sort result (or times out) and enforces a gap.
module capture_sequencer
  import capture_sequencer_pkg::*;
#(
  parameter int unsigned DataSize   = 4,
  parameter int unsigned Length     = DefLength,
  parameter int unsigned LengthSize = 6,
  parameter int unsigned GapCycles  = DefGapCycles,
  parameter int unsigned Timeout    = DefTimeout,
  parameter int unsigned ToSize     = 12
) (
  input  logic                  clk200,
  input  logic                  rstn,
  input  logic                  req_a_i,
  input  logic                  req_b_i,
  output logic                  grant_a_o,
  output logic                  grant_b_o,
  input  logic                  src_valid_i,
  input  logic [DataSize-1:0]   src_data_i,
  input  logic                  abort_i,
  input  logic                  result_tgl_i,
  output logic                  collect_o,
  output logic                  valid_o,
  output logic [DataSize-1:0]   data_o,
  output logic                  busy_o,
  output logic                  owner_o,
  output logic [LengthSize:0]   sample_cnt_o,
  output logic                  timeout_err_o
);

  localparam logic [LengthSize:0] CntFull = (LengthSize + 1)'(Length);
  localparam logic [LengthSize:0] CntLast = (LengthSize + 1)'(Length - 1);
  localparam logic [ToSize-1:0]   ToLast  = ToSize'(Timeout - 1);
  localparam logic [ToSize-1:0]   GapLast = ToSize'(GapCycles - 1);

  cs_state_e           state_q, state_d;
  owner_e              owner_q, owner_d, pick;
  logic                ran_q, ran_d;
  logic [ToSize-1:0]   tmr_q, tmr_d;
  logic [LengthSize:0] cnt_q, cnt_d;
  logic                grant_a_q, grant_a_d, grant_b_q, grant_b_d;
  logic                collect_q, collect_d, valid_q, valid_d, busy_q, busy_d;
  logic                terr_q, terr_d;
  logic [DataSize-1:0] data_q, data_d;
  logic                result_edge;

  capture_sequencer_tgl_sync u_tgl_sync (
    .clk_i  (clk200),
    .rst_ni (rstn),
    .tgl_i  (result_tgl_i),
    .edge_o (result_edge)
  );

  // Next-state and registered-output decode
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    ran_d     = ran_q;
    tmr_d     = tmr_q;
    cnt_d     = cnt_q;
    terr_d    = terr_q;
    data_d    = data_q;
    grant_a_d = 1'b0;
    grant_b_d = 1'b0;
    valid_d   = 1'b0;
    pick      = rr_pick(req_a_i, req_b_i, ran_q, owner_q);

    unique case (state_q)
      StIdle: begin
        if (req_a_i || req_b_i) begin
          owner_d   = pick;
          grant_a_d = (pick == OwnA);
          grant_b_d = (pick == OwnB);
          ran_d     = 1'b1;
          cnt_d     = '0;
          terr_d    = 1'b0;
          state_d   = StArm;
        end
      end
      StArm: begin
        state_d = StCapture;
      end
      StCapture: begin
        // A sample arriving with Abort is still forwarded
        if (src_valid_i && (cnt_q < CntFull)) begin
          valid_d = 1'b1;
          data_d  = src_data_i;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == CntLast) state_d = StDrain;
        end
        if (abort_i) state_d = StDrain;
        if (state_d == StDrain) tmr_d = '0;
      end
      StDrain: begin
        // Result edge takes priority over a coincident timeout
        if (result_edge) begin
          state_d = StGap;
          tmr_d   = '0;
        end else if (tmr_q == ToLast) begin
          terr_d  = 1'b1;
          state_d = StGap;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      StGap: begin
        if (tmr_q == GapLast) begin
          state_d = StIdle;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        tmr_d   = '0;
      end
    endcase

    collect_d = (state_d == StArm) || (state_d == StCapture);
    busy_d    = (state_d != StIdle);
  end

  // State and output registers
  always_ff @(posedge clk200 or negedge rstn) begin
    if (!rstn) begin
      state_q   <= StIdle;
      owner_q   <= OwnA;
      ran_q     <= 1'b0;
      tmr_q     <= '0;
      cnt_q     <= '0;
      terr_q    <= 1'b0;
      data_q    <= '0;
      grant_a_q <= 1'b0;
      grant_b_q <= 1'b0;
      valid_q   <= 1'b0;
      collect_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      ran_q     <= ran_d;
      tmr_q     <= tmr_d;
      cnt_q     <= cnt_d;
      terr_q    <= terr_d;
      data_q    <= data_d;
      grant_a_q <= grant_a_d;
      grant_b_q <= grant_b_d;
      valid_q   <= valid_d;
      collect_q <= collect_d;
      busy_q    <= busy_d;
    end
  end

  assign grant_a_o     = grant_a_q;
  assign grant_b_o     = grant_b_q;
  assign collect_o     = collect_q;
  assign valid_o       = valid_q;
  assign data_o        = data_q;
  assign busy_o        = busy_q;
  assign owner_o       = owner_q;
  assign sample_cnt_o  = cnt_q;
  assign timeout_err_o = terr_q;

endmodule
